multistart_sweep_ctrl: RTL
==========================

// Module: multistart_sweep_ctrl
// PURPOSE
//  Upstream controller for the gradient-descent minimiser (Top). Launches NUM_STARTS
//  runs with x_init = X_START + k*X_STEP (k = 0..NUM_STARTS-1) via start_op/done_op.
//  Keeps the lowest y_min over all runs, with its x and run index. Guards every run
//  with a timeout.
// PARAMETERS
//  NUM_STARTS     4             number of runs per sweep; legal range 1..255
//  X_START        32'hFFFFFC00  first x_init, signed Q24.8 (-4.0)
//  X_STEP         32'h00000200  x_init increment per run, signed Q24.8 (+2.0)
//  TIMEOUT_CYCLES 4096          max cycles in WAIT_DONE before abort; >=16
// PORTS
//  clk          in   1   clock
//  rst_n        in   1   asynchronous, active-low reset
//  sweep_start  in   1   1-cycle pulse: begin sweep; ignored while sweep_busy=1
//  sweep_busy   out  1   high from the cycle after an accepted start until done
//  sweep_done   out  1   1-cycle pulse at sweep end (normal or timeout)
//  sweep_err    out  1   sticky: last sweep aborted on timeout; cleared on next start
//  best_valid   out  1   at least one run of this sweep completed
//  best_x       out  32  signed Q24.8 x_at_min of best run
//  best_y       out  64  signed y_min of best run
//  best_idx     out  8   index k of best run
//  mz_start_op  out  1   to minimiser start_op (level)
//  mz_x_init    out  32  to minimiser x_init; stable while mz_start_op=1
//  mz_done_op   in   1   from minimiser done_op
//  mz_x_at_min  in   32  from minimiser x_at_min
//  mz_y_min     in   64  from minimiser y_min
// BEHAVIOUR
//  Reset values (async):
//   - all 1-bit outputs 0; mz_x_init, best_x, best_idx = 0
//   - best_y = 64'h7FFF_FFFF_FFFF_FFFF
//   - state IDLE; run counter k and timeout counter 0
//  FSM: IDLE -> LAUNCH -> WAIT_DONE -> CAPTURE -> RELEASE -> (LAUNCH | FINISH) -> IDLE
//  IDLE, on sweep_start:
//   - k = 0; mz_x_init = X_START
//   - best_* back to reset values; sweep_err = 0; sweep_busy = 1
//  LAUNCH (1 cycle):
//   - mz_start_op <= 1; clear timeout counter
//  WAIT_DONE:
//   - mz_start_op held at 1; timeout counter increments every cycle
//   - mz_done_op = 1 -> latch mz_x_at_min/mz_y_min into cand regs; go to CAPTURE
//   - counter reaches TIMEOUT_CYCLES-1 first -> sweep_err <= 1; go to FINISH
//   - done_op and timeout in the same cycle: done_op wins
//  CAPTURE (1 cycle):
//   - if !best_valid or cand_y < best_y (signed, strict):
//     best_x/best_y/best_idx <= cand/k; best_valid <= 1
//   - ties keep the earlier run
//   - mz_start_op <= 0
//  RELEASE:
//   - wait for mz_done_op = 0 (minimiser back in IDLE)
//   - then if k == NUM_STARTS-1 -> FINISH
//   - else k <= k+1, mz_x_init <= mz_x_init + X_STEP (32-bit two's complement wrap,
//     no saturation), go to LAUNCH
//   - this wait guarantees no start_op rising edge while the minimiser is in DONE
//  FINISH (1 cycle):
//   - mz_start_op <= 0; sweep_done <= 1 for one cycle
//   - sweep_busy <= 0; go to IDLE
//  Other rules:
//   - best_* change only in CAPTURE and at sweep start; hold between sweeps
//   - sweep_start while busy: ignored, no effect on state
//   - rst_n low mid-sweep: immediate return to reset values; no partial result kept
//  Minimum per-run overhead: 4 cycles plus minimiser latency
// STRUCTURE
//  Shared package (lr_pkg): Q24.8 width 32, Y width 64, Y_MAX 64'h7FFF..., FSM state
//  encodings.
//  One sub-module: the existing fixed_64_comp (a_in = cand_y, b_in = best_y, 1 if a<b).
//  k counter 8 bits; timeout counter $clog2(TIMEOUT_CYCLES) bits.
// TESTING (behavioural minimiser model: done_op after N cycles, y = (x-1.0)^2)
//  1 defaults, model N=20
//    -> x_init sequence FFFFFC00, FFFFFE00, 00000000, 00000200
//    -> best_idx=2 or 3 per model y, ties -> lower idx
//    -> sweep_done 1 pulse, busy low after it
//  2 model returns y = 5,3,3,9
//    -> best_y=3, best_idx=1; tie with run 2 not taken
//  3 model never raises done_op on run 1, TIMEOUT_CYCLES=64
//    -> sweep_err=1 and sweep_done at cycle 63 of WAIT_DONE
//    -> best_idx=0, best_valid=1
//  4 model holds done_op high 3 extra cycles after start_op falls
//    -> next mz_start_op rises only after done_op=0
//    -> x_init stable throughout each run
//  5 sweep_start pulsed during run 2
//    -> ignored, k continues
//    -> rst_n low in WAIT_DONE: all outputs at reset values next edge
//  6 X_START=32'h7FFFFF00, X_STEP=32'h00000200
//    -> second x_init wraps to 32'h80000100

Source files
------------

// File: rtl/multistart_sweep_ctrl_pkg.sv
// rtl/multistart_sweep_ctrl_pkg.sv - shared widths, constants and FSM encoding for the multistart sweep controller
package multistart_sweep_ctrl_pkg;

    localparam int Q_W = 32;
    localparam int Y_W = 64;
    localparam int K_W = 8;

    localparam logic [Y_W-1:0] Y_MAX = 64'h7FFF_FFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_CAPTURE   = 3'd3,
        ST_RELEASE   = 3'd4,
        ST_FINISH    = 3'd5
    } sweep_state_e;

endpackage

// File: rtl/multistart_sweep_ctrl_if.sv
// rtl/multistart_sweep_ctrl_if.sv - start/done handshake between the sweep controller and the minimiser
interface multistart_sweep_ctrl_if;
    import multistart_sweep_ctrl_pkg::*;

    logic           start_op;
    logic [Q_W-1:0] x_init;
    logic           done_op;
    logic [Q_W-1:0] x_at_min;
    logic [Y_W-1:0] y_min;

    modport master (
        output start_op,
        output x_init,
        input  done_op,
        input  x_at_min,
        input  y_min
    );

    modport slave (
        input  start_op,
        input  x_init,
        output done_op,
        output x_at_min,
        output y_min
    );

endinterface

// File: rtl/multistart_sweep_ctrl_comp.sv
// rtl/multistart_sweep_ctrl_comp.sv - signed 64-bit strict less-than comparator
module multistart_sweep_ctrl_comp
    import multistart_sweep_ctrl_pkg::*;
(
    input  logic [Y_W-1:0] a_in,
    input  logic [Y_W-1:0] b_in,
    output logic           lt
);

    assign lt = ($signed(a_in) < $signed(b_in));

endmodule

// File: rtl/multistart_sweep_ctrl.sv
// rtl/multistart_sweep_ctrl.sv - launches NUM_STARTS minimiser runs and keeps the lowest result, with a per-run timeout
module multistart_sweep_ctrl
    import multistart_sweep_ctrl_pkg::*;
#(
    parameter int unsigned    NUM_STARTS     = 4,
    parameter logic [Q_W-1:0] X_START        = 32'hFFFFFC00,
    parameter logic [Q_W-1:0] X_STEP         = 32'h00000200,
    parameter int unsigned    TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sweep_start,
    output logic                 sweep_busy,
    output logic                 sweep_done,
    output logic                 sweep_err,
    output logic                 best_valid,
    output logic [Q_W-1:0]       best_x,
    output logic [Y_W-1:0]       best_y,
    output logic [K_W-1:0]       best_idx,
    multistart_sweep_ctrl_if.master mz
);

    localparam int             T_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [T_W-1:0] T_LAST = T_W'(TIMEOUT_CYCLES - 1);
    localparam logic [K_W-1:0] K_LAST = K_W'(NUM_STARTS - 1);

    sweep_state_e   state_q;
    sweep_state_e   state_d;
    logic [K_W-1:0] k_q;
    logic [T_W-1:0] tcnt_q;
    logic           start_op_q;
    logic [Q_W-1:0] x_init_q;
    logic [Q_W-1:0] cand_x_q;
    logic [Y_W-1:0] cand_y_q;
    logic           cand_lt;
    logic           timeout_hit;

    assign mz.start_op = start_op_q;
    assign mz.x_init   = x_init_q;
    assign timeout_hit = (tcnt_q == T_LAST);

    multistart_sweep_ctrl_comp u_comp (
        .a_in (cand_y_q),
        .b_in (best_y),
        .lt   (cand_lt)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (sweep_start) state_d = ST_LAUNCH;
            ST_LAUNCH:    state_d = ST_WAIT_DONE;
            // done_op is tested first so a result arriving on the last timeout cycle still counts
            ST_WAIT_DONE: begin
                if (mz.done_op)       state_d = ST_CAPTURE;
                else if (timeout_hit) state_d = ST_FINISH;
            end
            ST_CAPTURE:   state_d = ST_RELEASE;
            ST_RELEASE: begin
                if (!mz.done_op) state_d = (k_q == K_LAST) ? ST_FINISH : ST_LAUNCH;
            end
            ST_FINISH:    state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            tcnt_q     <= '0;
            start_op_q <= 1'b0;
            x_init_q   <= '0;
            cand_x_q   <= '0;
            cand_y_q   <= '0;
            sweep_busy <= 1'b0;
            sweep_done <= 1'b0;
            sweep_err  <= 1'b0;
            best_valid <= 1'b0;
            best_x     <= '0;
            best_y     <= Y_MAX;
            best_idx   <= '0;
        end else begin
            state_q    <= state_d;
            sweep_done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (sweep_start) begin
                        k_q        <= '0;
                        x_init_q   <= X_START;
                        best_valid <= 1'b0;
                        best_x     <= '0;
                        best_y     <= Y_MAX;
                        best_idx   <= '0;
                        sweep_err  <= 1'b0;
                        sweep_busy <= 1'b1;
                    end
                end
                ST_LAUNCH: begin
                    start_op_q <= 1'b1;
                    tcnt_q     <= '0;
                end
                ST_WAIT_DONE: begin
                    if (mz.done_op) begin
                        cand_x_q <= mz.x_at_min;
                        cand_y_q <= mz.y_min;
                    end else if (timeout_hit) begin
                        sweep_err <= 1'b1;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    // strict compare: an equal y keeps the earlier run
                    if (!best_valid || cand_lt) begin
                        best_x     <= cand_x_q;
                        best_y     <= cand_y_q;
                        best_idx   <= k_q;
                        best_valid <= 1'b1;
                    end
                    start_op_q <= 1'b0;
                end
                ST_RELEASE: begin
                    // holding here until done_op drops keeps start_op from rising while the minimiser sits in DONE
                    if (!mz.done_op && (k_q != K_LAST)) begin
                        k_q      <= k_q + 1'b1;
                        x_init_q <= x_init_q + X_STEP;
                    end
                end
                ST_FINISH: begin
                    start_op_q <= 1'b0;
                    sweep_done <= 1'b1;
                    sweep_busy <= 1'b0;
                end
                default: begin
                    start_op_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
